// File: rtl/tmds_pkg.sv
// Constants and helpers shared by the TMDS channel encoder stages.
package tmds_pkg;

    localparam logic [9:0] CTRL_SYM_0 = 10'h354;
    localparam logic [9:0] CTRL_SYM_1 = 10'h0AB;
    localparam logic [9:0] CTRL_SYM_2 = 10'h154;
    localparam logic [9:0] CTRL_SYM_3 = 10'h2AB;

    // Which of the three DC-balancing rules applies to an active symbol.
    typedef enum logic [1:0] {
        ENC_BAL  = 2'd0,
        ENC_INV  = 2'd1,
        ENC_PASS = 2'd2
    } enc_case_e;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] ctl);
        logic [9:0] sym;
        case (ctl)
            2'b00:   sym = CTRL_SYM_0;
            2'b01:   sym = CTRL_SYM_1;
            2'b10:   sym = CTRL_SYM_2;
            default: sym = CTRL_SYM_3;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle of one TMDS channel: video/control in, symbol and disparity out.
interface tmds_channel_encoder_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 5
);
    logic [PIX_W-1:0]        i_pix;
    logic                    i_de;
    logic [1:0]              i_ctl;
    logic [9:0]              o_tx_word;
    logic signed [CNT_W-1:0] o_disparity;

    modport master (
        output i_pix, i_de, i_ctl,
        input  o_tx_word, o_disparity
    );

    modport slave (
        input  i_pix, i_de, i_ctl,
        output o_tx_word, o_disparity
    );
endinterface

// File: rtl/tmds_qm_stage.sv
// First encoder stage: replicate the pixel to 8 bits, apply XOR/XNOR transition
// minimisation and register q_m with its ones count and the delayed de/ctl.
module tmds_qm_stage
    import tmds_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PIX_W-1:0] i_pix,
    input  logic             i_de,
    input  logic [1:0]       i_ctl,
    output logic [8:0]       o_qm,
    output logic [3:0]       o_n1,
    output logic             o_de,
    output logic [1:0]       o_ctl
);

    logic [7:0] d;
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_d, qm_q;
    logic [3:0] n1_q;
    logic       de_q;
    logic [1:0] ctl_q;

    // MSB-first replication so a 1-bit pixel becomes 0x00 / 0xFF.
    for (genvar gi = 0; gi < 8; gi++) begin : g_expand
        assign d[7-gi] = i_pix[PIX_W-1-(gi % PIX_W)];
    end

    assign n1d      = ones8(d);
    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);

    always_comb begin
        qm_d    = '0;
        qm_d[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d[i]) : (qm_d[i-1] ^ d[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            qm_q  <= '0;
            n1_q  <= '0;
            de_q  <= 1'b0;
            ctl_q <= '0;
        end else begin
            qm_q  <= qm_d;
            n1_q  <= ones8(qm_d[7:0]);
            de_q  <= i_de;
            ctl_q <= i_ctl;
        end
    end

    assign o_qm  = qm_q;
    assign o_n1  = n1_q;
    assign o_de  = de_q;
    assign o_ctl = ctl_q;

endmodule

// File: rtl/tmds_channel_encoder.sv
// DVI TMDS 8b/10b encoder for one channel: transition minimisation stage followed
// by a DC-balancing stage that tracks signed running disparity.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int CNT_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    tmds_channel_encoder_if.slave bus
);

    localparam logic signed [CNT_W-1:0] ZERO = '0;
    localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);

    logic [8:0] qm;
    logic [3:0] n1;
    logic       de_s1;
    logic [1:0] ctl_s1;

    tmds_qm_stage #(
        .PIX_W (PIX_W)
    ) u_qm_stage (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_pix (bus.i_pix),
        .i_de  (bus.i_de),
        .i_ctl (bus.i_ctl),
        .o_qm  (qm),
        .o_n1  (n1),
        .o_de  (de_s1),
        .o_ctl (ctl_s1)
    );

    logic [9:0]              word_d, word_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;
    logic signed [CNT_W-1:0] ones_minus_zeros;
    enc_case_e               enc_sel;

    // N1 - N0 = 2*N1 - 8
    assign ones_minus_zeros = $signed(CNT_W'({n1, 1'b0})) - $signed(CNT_W'(8));

    always_comb begin
        if ((cnt_q == ZERO) || (n1 == 4'd4)) begin
            enc_sel = ENC_BAL;
        end else if ((!cnt_q[CNT_W-1] && (n1 > 4'd4)) ||
                     ( cnt_q[CNT_W-1] && (n1 < 4'd4))) begin
            enc_sel = ENC_INV;
        end else begin
            enc_sel = ENC_PASS;
        end
    end

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (!de_s1) begin
            word_d = ctrl_symbol(ctl_s1);
            cnt_d  = ZERO;
        end else begin
            case (enc_sel)
                ENC_BAL: begin
                    word_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                    cnt_d  = qm[8] ? (cnt_q + ones_minus_zeros) : (cnt_q - ones_minus_zeros);
                end
                ENC_INV: begin
                    word_d = {1'b1, qm[8], ~qm[7:0]};
                    cnt_d  = cnt_q + (qm[8] ? TWO : ZERO) - ones_minus_zeros;
                end
                ENC_PASS: begin
                    word_d = {1'b0, qm[8], qm[7:0]};
                    cnt_d  = cnt_q - (qm[8] ? ZERO : TWO) + ones_minus_zeros;
                end
                default: begin
                    word_d = word_q;
                    cnt_d  = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_q <= '0;
            cnt_q  <= ZERO;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.o_tx_word   = word_q;
    assign bus.o_disparity = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed-vector bench for the TMDS channel encoder (8-bit and 1-bit pixel builds).
module tb_tmds_channel_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmds_channel_encoder_if #(.PIX_W(8), .CNT_W(5)) bus8 ();
    tmds_channel_encoder_if #(.PIX_W(1), .CNT_W(5)) bus1 ();

    tmds_channel_encoder #(.PIX_W(8), .CNT_W(5)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8)
    );

    tmds_channel_encoder #(.PIX_W(1), .CNT_W(5)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    typedef struct {
        logic       de;
        logic [1:0] ctl;
        logic [7:0] pix;
        logic [9:0] word;
        int         disp;
    } vec_t;

    vec_t tab8[$];
    vec_t tab1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic de, input logic [1:0] ctl, input logic [7:0] pix,
                                input logic [9:0] word, input int disp);
        vec_t v;
        v.de   = de;
        v.ctl  = ctl;
        v.pix  = pix;
        v.word = word;
        v.disp = disp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [9:0] aw, input logic [9:0] ew,
                       input int ad, input int ed);
        $display("%s: word=%03h (exp %03h) disp=%0d (exp %0d)", name, aw, ew, ad, ed);
        n_cmp++;
        if (aw !== ew) begin
            n_err++;
            $display("FAIL %s word: got %03h expected %03h", name, aw, ew);
        end
        n_cmp++;
        if (ad != ed) begin
            n_err++;
            $display("FAIL %s disparity: got %0d expected %0d", name, ad, ed);
        end
    endtask

    task automatic drive(input vec_t v);
        bus8.i_de  = v.de;
        bus8.i_ctl = v.ctl;
        bus8.i_pix = v.pix;
        bus1.i_de  = v.de;
        bus1.i_ctl = v.ctl;
        bus1.i_pix = v.pix[0];
    endtask

    // Vector k is sampled on one edge and must appear after the following edge.
    task automatic run_table(input vec_t tab[$], input bit use1, input string tag);
        vec_t blank;
        blank = mk(1'b0, 2'b00, 8'h00, 10'h000, 0);
        for (int k = 0; k <= tab.size(); k++) begin
            if (k < tab.size()) drive(tab[k]);
            else                drive(blank);
            @(posedge clk);
            #1;
            if (k >= 1) begin
                chk($sformatf("%s[%0d]", tag, k - 1),
                    use1 ? bus1.o_tx_word : bus8.o_tx_word, tab[k-1].word,
                    int'(use1 ? bus1.o_disparity : bus8.o_disparity), tab[k-1].disp);
            end
        end
    endtask

    initial begin
        // 8-bit pixel stream: control symbols, DC-balance branches, N1==4 boundaries.
        tab8.push_back(mk(1'b0, 2'b00, 8'h00, 10'h354, 0));
        tab8.push_back(mk(1'b0, 2'b01, 8'h00, 10'h0AB, 0));
        tab8.push_back(mk(1'b0, 2'b10, 8'h00, 10'h154, 0));
        tab8.push_back(mk(1'b0, 2'b11, 8'h00, 10'h2AB, 0));
        tab8.push_back(mk(1'b1, 2'b00, 8'h00, 10'h100, -8));
        tab8.push_back(mk(1'b1, 2'b00, 8'h00, 10'h3FF, 2));
        tab8.push_back(mk(1'b1, 2'b00, 8'h00, 10'h100, -6));
        tab8.push_back(mk(1'b1, 2'b00, 8'h00, 10'h3FF, 4));
        tab8.push_back(mk(1'b0, 2'b00, 8'h00, 10'h354, 0));
        tab8.push_back(mk(1'b1, 2'b00, 8'hFF, 10'h200, -8));
        tab8.push_back(mk(1'b1, 2'b00, 8'hFF, 10'h0FF, -2));
        tab8.push_back(mk(1'b0, 2'b01, 8'hAA, 10'h0AB, 0));
        tab8.push_back(mk(1'b1, 2'b11, 8'h10, 10'h1F0, 0));
        tab8.push_back(mk(1'b1, 2'b00, 8'h55, 10'h133, 0));
        tab8.push_back(mk(1'b1, 2'b00, 8'hAA, 10'h233, 0));
        tab8.push_back(mk(1'b1, 2'b00, 8'h00, 10'h100, -8));
        tab8.push_back(mk(1'b1, 2'b00, 8'hAA, 10'h233, -8));
        tab8.push_back(mk(1'b1, 2'b00, 8'h01, 10'h1FF, 0));
        tab8.push_back(mk(1'b1, 2'b00, 8'hFE, 10'h2FF, 8));
        tab8.push_back(mk(1'b1, 2'b00, 8'hFE, 10'h000, -2));
        tab8.push_back(mk(1'b1, 2'b00, 8'h01, 10'h1FF, 6));
        tab8.push_back(mk(1'b1, 2'b00, 8'h01, 10'h300, 0));
        tab8.push_back(mk(1'b1, 2'b00, 8'h00, 10'h100, -8));
        tab8.push_back(mk(1'b1, 2'b00, 8'hFE, 10'h2FF, 0));
        tab8.push_back(mk(1'b0, 2'b10, 8'h00, 10'h154, 0));

        // 1-bit pixel stream reproduces the legacy two-level symbol set.
        tab1.push_back(mk(1'b0, 2'b00, 8'h00, 10'h354, 0));
        tab1.push_back(mk(1'b1, 2'b00, 8'h01, 10'h200, -8));
        tab1.push_back(mk(1'b1, 2'b00, 8'h01, 10'h0FF, -2));
        tab1.push_back(mk(1'b1, 2'b00, 8'h00, 10'h3FF, 8));
        tab1.push_back(mk(1'b1, 2'b00, 8'h00, 10'h100, 0));
        tab1.push_back(mk(1'b0, 2'b00, 8'h00, 10'h354, 0));

        rst = 1'b1;
        drive(mk(1'b0, 2'b00, 8'h00, 10'h000, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset8", bus8.o_tx_word, 10'h000, int'(bus8.o_disparity), 0);
        chk("reset1", bus1.o_tx_word, 10'h000, int'(bus1.o_disparity), 0);
        @(negedge clk);
        rst = 1'b0;

        run_table(tab8, 1'b0, "pix8");
        run_table(tab1, 1'b1, "pix1");

        // Mid-line reset with non-zero disparity, then restart from cnt = 0.
        drive(mk(1'b1, 2'b00, 8'h00, 10'h000, 0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midline_pre0", bus8.o_tx_word, 10'h100, int'(bus8.o_disparity), -8);
        @(posedge clk);
        #1;
        chk("midline_pre1", bus8.o_tx_word, 10'h3FF, int'(bus8.o_disparity), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midline_rst", bus8.o_tx_word, 10'h000, int'(bus8.o_disparity), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1'b1, 2'b00, 8'hFF, 10'h000, 0));
        @(posedge clk);
        #1;
        chk("post_rst_blank", bus8.o_tx_word, 10'h354, int'(bus8.o_disparity), 0);
        drive(mk(1'b0, 2'b00, 8'h00, 10'h000, 0));
        @(posedge clk);
        #1;
        chk("post_rst_first", bus8.o_tx_word, 10'h200, int'(bus8.o_disparity), -8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Full DVI 1.0 TMDS 8b/10b encoder for one channel; successor to the 1-bit two-symbol pixel encoder.
- Accepts a PIX_W-bit pixel and expands it to 8 bits by bit replication, so PIX_W=1 reproduces the two-level 0x00/0xFF output.
- Performs transition minimisation (XOR/XNOR) and DC balancing with a signed running-disparity counter, and emits the four control symbols during blanking.
- Two-stage pipeline. Instantiated once per channel (B, G, R), upstream of the 10:1 serialiser.

Parameters:
- PIX_W, 8: pixel input width, 1..8. Expanded to 8 bits as d[7-k] = i_pix[PIX_W-1-(k mod PIX_W)].
- CNT_W, 5: width of the signed disparity counter. Must be >= 5.

Ports:
- i_clk, input, 1: pixel clock.
- i_rst, input, 1: reset, asynchronous, active-high.
- i_pix, input, PIX_W: pixel value, sampled when i_de=1.
- i_de, input, 1: data enable. 1 = active video, 0 = blanking.
- i_ctl, input, 2: control bits {C1,C0}. Channel 0 wires {vs,hs}.
- o_tx_word, output, 10: TMDS symbol, bit 0 transmitted first.
- o_disparity, output, CNT_W: signed running disparity after the symbol now on o_tx_word. Used for verification.

Behaviour:
- Reset (async, while i_rst=1): o_tx_word=10'h000, o_disparity=0, all pipeline registers=0, stage-1 de=0.
- Latency: exactly 2 cycles from input sample to o_tx_word. i_de and i_ctl are delayed alongside the data. Throughput is one symbol per clock, no stalls.
- Stage 1 (registered):
  - Expand i_pix to d[7:0] and count N1d = ones(d).
  - If N1d>4, or N1d==4 with d[0]==0: q_m[0]=d[0], q_m[i]=XNOR(q_m[i-1],d[i]), q_m[8]=0.
  - Otherwise: q_m[i]=XOR(q_m[i-1],d[i]), q_m[8]=1.
  - Register q_m[8:0], N1=ones(q_m[7:0]) (4-bit), de and ctl.
- Stage 2 (registered), with de=1 and cnt = current disparity. N0 = 8-N1.
  - (a) cnt==0 or N1==4: out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m8 ? (N1-N0) : (N0-N1).
  - (b) else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m8, ~q_m[7:0]}. cnt += 2*q_m8 + (N0-N1).
  - (c) else: out = {0, q_m8, q_m[7:0]}. cnt += -2*(~q_m8) + (N1-N0).
- Stage 2 with de=0: out per ctl 00→10'h354, 01→10'h0AB, 10→10'h154, 11→10'h2AB, and cnt=0.
- Arithmetic is signed CNT_W bits throughout. For valid streams |cnt| stays <= 10, so no saturation logic is needed.
- de toggling on back-to-back cycles is legal. Each symbol is judged on its own delayed de.
- Pixel content during blanking is ignored. i_ctl during active video is ignored.
- Reset mid-line: outputs go to reset values immediately, and the first post-reset active symbol starts from cnt=0.

Decomposition:
- Shared package tmds_pkg holds the constants CTRL_SYM_0..3 and the function ones8 (popcount of 8 bits).
- One natural sub-module: tmds_qm_stage (stage 1: expansion plus transition minimisation, registered). Stage 2 stays in the top.

Test Plan:
- Reset, then de=0 with ctl=00,01,10,11 → after 2 cycles o_tx_word = 0x354, 0x0AB, 0x154, 0x2AB; o_disparity=0 throughout.
- PIX_W=8, de=1, pix=0x00 for four cycles from cnt=0 → o_tx_word = 0x100, 0x3FF, 0x100, 0x3FF; o_disparity = -8, 2, -6, 4.
- PIX_W=8, pix=0xFF for two cycles from cnt=0 → 0x200 then 0x0FF; o_disparity = -8 then -2.
- PIX_W=1, pix=1,1,0,0 after blanking → 0x200, 0x0FF, 0x3FF, 0x100, matching the legacy two-level symbol set.
- Random 8-bit pixels with blanking gaps, 10k symbols → matches the reference model; cumulative ones-minus-zeros per active line stays within ±10; a decoder model recovers every pixel.
- Assert i_rst for one cycle mid-line with cnt≠0 → o_tx_word=0 and o_disparity=0 immediately; the next active symbol is encoded as if cnt=0.
